vga_fifo_reader: RTL

- Consumer end of the 4-deep pixel `fifo`. Generates VGA raster timing and pops one FIFO word per active pixel.
- Drives registered RGB, sync and data-enable to the DAC/pins.
- Flags underflow when the FIFO runs dry inside the active area.
- Sits between the pixel-producer/`fifo` pair and the board VGA connector.

---
 rtl/vga_fifo_reader.sv | 77 +++++++
 1 files changed

// File: rtl/vga_fifo_reader.sv
// vga_fifo_reader: VGA raster timing generator that pops one FIFO word per active pixel
module vga_fifo_reader #(
  parameter int W        = 32,
  parameter int PIX_W    = 12,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [W-1:0]     fifo_data,
  input  logic             fifo_empty,
  output logic             fifo_re,
  output logic [PIX_W-1:0] rgb,
  output logic             hsync,
  output logic             vsync,
  output logic             de,
  output logic             frame_start,
  output logic             underflow,
  input  logic             clr_underflow
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state, state_nxt;
  logic [HW-1:0] hcnt;
  logic [VW-1:0] vcnt;
  logic hwrap, origin, last, active, hs_n, vs_n, run_now, starve;
  logic unused;
  assign unused = &{1'b0, fifo_data[W-1:PIX_W]};
  always_comb begin
    hwrap   = hcnt == HW'(H_TOTAL - 1);
    origin  = hcnt == '0 && vcnt == '0;
    last    = hwrap && vcnt == VW'(V_TOTAL - 1);
    active  = hcnt < HW'(H_ACTIVE) && vcnt < VW'(V_ACTIVE);
    hs_n    = !(hcnt >= HW'(H_ACTIVE + H_FP) && hcnt < HW'(H_ACTIVE + H_FP + H_SYNC));
    vs_n    = !(vcnt >= VW'(V_ACTIVE + V_FP) && vcnt < VW'(V_ACTIVE + V_FP + V_SYNC));
    // A frame may start in the same clock IDLE sees the origin with enable high
    run_now = state == RUN || (state == IDLE && enable && origin);
    fifo_re = reset && run_now && active && !fifo_empty;
    starve  = run_now && active && fifo_empty;
    state_nxt = state == IDLE ? (enable && origin ? RUN : IDLE)
              : state == RUN  ? (last && !enable ? DRAIN : RUN)
              : IDLE;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      hcnt        <= '0;
      vcnt        <= '0;
      rgb         <= '0;
      de          <= 1'b0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      frame_start <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      state       <= state_nxt;
      hcnt        <= hwrap ? '0 : hcnt + 1'b1;
      if (hwrap) vcnt <= last ? '0 : vcnt + 1'b1;
      rgb         <= fifo_re ? fifo_data[PIX_W-1:0] : '0;
      de          <= active;
      hsync       <= hs_n;
      vsync       <= vs_n;
      frame_start <= run_now && origin;
      underflow   <= starve || (underflow && !clr_underflow);
    end
  end
endmodule
